// File: rtl/ide_pio_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : ide_pio_engine_if
// Brief   : Requester-side register-cycle handshake for the IDE PIO engine.
// Revision: 1.0
// ============================================================================
interface ide_pio_engine_if;
  logic        ata_rd;
  logic        ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out;
  logic        ata_done;

  modport master (
    output ata_rd, ata_wr, ata_addr, ata_in,
    input  ata_out, ata_done
  );

  modport slave (
    input  ata_rd, ata_wr, ata_addr, ata_in,
    output ata_out, ata_done
  );
endinterface
`default_nettype wire

// File: rtl/ide_pio_engine.sv
`default_nettype none
// ============================================================================
// Module  : ide_pio_engine
// Brief   : Turns one-word ATA register requests into timed PIO bus cycles.
// Revision: 1.0
// ============================================================================
module ide_pio_engine #(
  parameter int T_SETUP   = 4,
  parameter int T_STROBE  = 9,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  ide_pio_engine_if.slave   ata,
  inout  wire  [15:0]       ide_data_bus,
  output logic              ide_dior,
  output logic              ide_diow,
  output logic [1:0]        ide_cs,
  output logic [2:0]        ide_da
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  localparam logic [7:0] c_setup_ld   = 8'(T_SETUP - 1);
  localparam logic [7:0] c_strobe_ld  = 8'(T_STROBE - 1);
  localparam logic [7:0] c_hold_ld    = 8'(T_HOLD - 1);
  localparam logic [7:0] c_recover_ld = 8'(T_RECOVER - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_is_read;
  logic        r_oe;
  logic [15:0] r_wdata;
  logic        w_cnt_zero;

  assign w_cnt_zero   = (r_cnt == 8'd0);
  assign ide_data_bus = r_oe ? r_wdata : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_is_read    <= 1'b0;
      r_oe         <= 1'b0;
      r_wdata      <= 16'h0000;
      ide_dior     <= 1'b1;
      ide_diow     <= 1'b1;
      ide_cs       <= 2'b11;
      ide_da       <= 3'd0;
      ata.ata_done <= 1'b0;
      ata.ata_out  <= 16'h0000;
    end else begin
      ata.ata_done <= 1'b0;
      r_cnt        <= r_cnt - 8'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 8'd0;
          if (ata.ata_rd || ata.ata_wr) begin
            // Read wins a simultaneous request, so the bus is never driven.
            r_state   <= S_SETUP;
            r_cnt     <= c_setup_ld;
            r_is_read <= ata.ata_rd;
            r_oe      <= !ata.ata_rd;
            r_wdata   <= ata.ata_in;
            ide_cs    <= ata.ata_addr[4:3];
            ide_da    <= (ata.ata_addr[4:3] == 2'b11) ? 3'd0 : ata.ata_addr[2:0];
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_state  <= S_STROBE;
            r_cnt    <= c_strobe_ld;
            ide_dior <= !r_is_read;
            ide_diow <= r_is_read;
          end
        end
        S_STROBE: begin
          if (w_cnt_zero) begin
            if (r_is_read) begin
              ata.ata_out <= ide_data_bus;
            end
            r_state  <= S_HOLD;
            r_cnt    <= c_hold_ld;
            ide_dior <= 1'b1;
            ide_diow <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            r_state      <= S_DONE;
            r_cnt        <= 8'd0;
            r_oe         <= 1'b0;
            ide_cs       <= 2'b11;
            ide_da       <= 3'd0;
            ata.ata_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_RECOVER;
          r_cnt   <= c_recover_ld;
        end
        S_RECOVER: begin
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ide_pio_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_ide_pio_engine
// Brief   : Randomised checks of the IDE PIO engine against a timeline model.
// Revision: 1.0
// ============================================================================
module tb_ide_pio_engine;
  localparam int TS      = 4;
  localparam int TT      = 9;
  localparam int TH      = 2;
  localparam int TR      = 15;
  localparam int DONE_AT = TS + TT + TH + 1;
  localparam int PERIOD  = TS + TT + TH + TR + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  wire  [15:0] ide_data_bus;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  ide_pio_engine_if ata_if();

  ide_pio_engine #(
    .T_SETUP   (TS),
    .T_STROBE  (TT),
    .T_HOLD    (TH),
    .T_RECOVER (TR)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ata          (ata_if),
    .ide_data_bus (ide_data_bus),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da)
  );

  // Device answers reads while DIOR- is low; otherwise it parks the bus at 0
  // whenever the host is not supposed to be driving it.
  logic [15:0] dev_word;
  logic        park;
  assign ide_data_bus = (ide_dior == 1'b0) ? dev_word : (park ? 16'h0000 : 16'hzzzz);

  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_out;
  logic [15:0] dev_q[$];
  logic [39:0] s_sig[1:128];

  // {dior, diow, cs, da, done, bus, ata_out} expected k cycles after acceptance
  function automatic logic [39:0] model_sig(input int k, input int ntx, input logic is_rd,
                                            input logic [4:0] addr, input logic [15:0] din,
                                            input logic [15:0] dev0, input logic [15:0] dev1,
                                            input logic [15:0] old_out);
    int          tx;
    int          m;
    int          ph;
    logic [15:0] dev;
    logic [15:0] bus;
    logic [15:0] outv;
    logic [1:0]  cs;
    logic [2:0]  da;
    logic        dior;
    logic        diow;
    logic        done;
    tx  = (k - 1) / PERIOD;
    m   = (k - 1) % PERIOD + 1;
    dev = (tx == 0) ? dev0 : dev1;
    ph  = 0;
    if (tx < ntx) begin
      if (m <= TS) ph = 1;
      else if (m <= TS + TT) ph = 2;
      else if (m <= TS + TT + TH) ph = 3;
      else if (m == DONE_AT) ph = 4;
    end
    cs   = (ph >= 1 && ph <= 3) ? addr[4:3] : 2'b11;
    da   = (cs == 2'b11) ? 3'd0 : addr[2:0];
    dior = !(is_rd && ph == 2);
    diow = !(!is_rd && ph == 2);
    done = (ph == 4);
    bus  = 16'h0000;
    if (!is_rd && ph >= 1 && ph <= 3) bus = din;
    else if (is_rd && ph == 2) bus = dev;
    outv = old_out;
    if (is_rd) begin
      for (int t = 0; t < ntx; t++) begin
        if (k >= t * PERIOD + TS + TT + 1) outv = (t == 0) ? dev0 : dev1;
      end
    end
    return {dior, diow, cs, da, done, bus, outv};
  endfunction

  // Issues one request at a negedge and records ncyc cycles of outputs.
  task automatic run_txn(input logic rd, input logic wr, input logic [4:0] addr,
                         input logic [15:0] din, input int ncyc, input int drop_cycle,
                         input int drop_done, output int ndone, output int first_done,
                         output int last_done);
    int  m;
    int  tx;
    logic drives;
    ndone      = 0;
    first_done = 0;
    last_done  = 0;
    ata_if.ata_rd   = rd;
    ata_if.ata_wr   = wr;
    ata_if.ata_addr = addr;
    ata_if.ata_in   = din;
    for (int k = 1; k <= ncyc; k++) begin
      tx     = (k - 1) / PERIOD;
      m      = (k - 1) % PERIOD + 1;
      drives = wr && !rd && (tx < drop_done) && (m <= TS + TT + TH);
      park   = !drives;
      @(posedge clk);
      @(negedge clk);
      s_sig[k] = {ide_dior, ide_diow, ide_cs, ide_da, ata_if.ata_done, ide_data_bus, ata_if.ata_out};
      if (ata_if.ata_done) begin
        ndone++;
        if (first_done == 0) first_done = k;
        last_done = k;
        if (dev_q.size() > 0) dev_word = dev_q.pop_front();
        if (ndone == drop_done) begin
          ata_if.ata_rd = 1'b0;
          ata_if.ata_wr = 1'b0;
        end
      end
      if (k == drop_cycle) begin
        ata_if.ata_rd = 1'b0;
        ata_if.ata_wr = 1'b0;
      end
    end
    park = 1'b1;
  endtask

  task automatic test_reset();
    ata_if.ata_rd = 1'b0;
    ata_if.ata_wr = 1'b0;
    ata_if.ata_addr = 5'd0;
    ata_if.ata_in = 16'h0;
    park = 1'b1;
    dev_word = 16'h0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ide_dior !== 1'b1) begin errors++; $display("FAIL reset_dior got %b exp 1", ide_dior); end
    checks++; if (ide_diow !== 1'b1) begin errors++; $display("FAIL reset_diow got %b exp 1", ide_diow); end
    checks++; if (ide_cs !== 2'b11) begin errors++; $display("FAIL reset_cs got %b exp 11", ide_cs); end
    checks++; if (ide_da !== 3'd0) begin errors++; $display("FAIL reset_da got %b exp 000", ide_da); end
    checks++; if (ata_if.ata_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ata_if.ata_done); end
    checks++; if (ata_if.ata_out !== 16'h0) begin errors++; $display("FAIL reset_out got %h exp 0000", ata_if.ata_out); end
    checks++; if (ide_data_bus !== 16'h0) begin errors++; $display("FAIL reset_bus got %h exp 0000", ide_data_bus); end
    reset_n = 1'b1;
    exp_out = 16'h0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [4:0]  addr;
    logic [15:0] dev;
    logic [39:0] exp_sig;
    int nd, fd, ld;
    for (int i = 0; i < 5; i++) begin
      addr = (i == 0) ? 5'b10111 : 5'($urandom);
      dev  = (i == 0) ? 16'h0050 : 16'($urandom);
      dev_word = dev;
      run_txn(1'b1, 1'b0, addr, 16'($urandom), PERIOD, 0, 1, nd, fd, ld);
      for (int k = 1; k <= PERIOD; k++) begin
        exp_sig = model_sig(k, 1, 1'b1, addr, 16'h0, dev, dev, exp_out);
        checks++;
        if (s_sig[k] !== exp_sig) begin
          errors++;
          $display("FAIL read%0d cycle %0d got %h exp %h", i, k, s_sig[k], exp_sig);
        end
      end
      checks++;
      if (fd !== DONE_AT || nd !== 1) begin
        errors++;
        $display("FAIL read%0d done got cycle %0d count %0d exp cycle %0d count 1", i, fd, nd, DONE_AT);
      end
      exp_out = dev;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_write();
    logic [4:0]  addr;
    logic [15:0] din;
    logic [39:0] exp_sig;
    int nd, fd, ld;
    for (int i = 0; i < 5; i++) begin
      addr = (i == 0) ? 5'b10110 : 5'($urandom);
      din  = (i == 0) ? 16'h0040 : 16'($urandom);
      dev_word = 16'hDEAD;
      run_txn(1'b0, 1'b1, addr, din, PERIOD, 0, 1, nd, fd, ld);
      for (int k = 1; k <= PERIOD; k++) begin
        exp_sig = model_sig(k, 1, 1'b0, addr, din, 16'h0, 16'h0, exp_out);
        checks++;
        if (s_sig[k] !== exp_sig) begin
          errors++;
          $display("FAIL write%0d cycle %0d got %h exp %h", i, k, s_sig[k], exp_sig);
        end
      end
      checks++;
      if (fd !== DONE_AT || nd !== 1) begin
        errors++;
        $display("FAIL write%0d done got cycle %0d count %0d exp cycle %0d count 1", i, fd, nd, DONE_AT);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp_sig;
    int nd, fd, ld;
    dev_word = 16'h1234;
    dev_q.delete();
    dev_q.push_back(16'hABCD);
    run_txn(1'b1, 1'b0, 5'b10111, 16'h0, 2 * PERIOD, 0, 2, nd, fd, ld);
    for (int k = 1; k <= 2 * PERIOD; k++) begin
      exp_sig = model_sig(k, 2, 1'b1, 5'b10111, 16'h0, 16'h1234, 16'hABCD, exp_out);
      checks++;
      if (s_sig[k] !== exp_sig) begin
        errors++;
        $display("FAIL b2b cycle %0d got %h exp %h", k, s_sig[k], exp_sig);
      end
    end
    checks++;
    if (nd !== 2 || (ld - fd) !== PERIOD) begin
      errors++;
      $display("FAIL b2b_period got count %0d spacing %0d exp count 2 spacing %0d", nd, ld - fd, PERIOD);
    end
    exp_out = 16'hABCD;
    dev_q.delete();
    @(negedge clk);
  endtask

  task automatic test_both_requests();
    logic [39:0] exp_sig;
    int nd, fd, ld;
    dev_word = 16'h5A5A;
    run_txn(1'b1, 1'b1, 5'b10000, 16'hFFFF, PERIOD, 0, 1, nd, fd, ld);
    for (int k = 1; k <= PERIOD; k++) begin
      exp_sig = model_sig(k, 1, 1'b1, 5'b10000, 16'hFFFF, 16'h5A5A, 16'h5A5A, exp_out);
      checks++;
      if (s_sig[k] !== exp_sig) begin
        errors++;
        $display("FAIL both cycle %0d got %h exp %h", k, s_sig[k], exp_sig);
      end
    end
    exp_out = 16'h5A5A;
    @(negedge clk);
  endtask

  task automatic test_drop();
    logic [39:0] exp_sig;
    int nd, fd, ld;
    run_txn(1'b0, 1'b1, 5'b10110, 16'h00C3, PERIOD + 16, 2, 1, nd, fd, ld);
    for (int k = 1; k <= PERIOD + 16; k++) begin
      exp_sig = model_sig(k, 1, 1'b0, 5'b10110, 16'h00C3, 16'h0, 16'h0, exp_out);
      checks++;
      if (s_sig[k] !== exp_sig) begin
        errors++;
        $display("FAIL drop cycle %0d got %h exp %h", k, s_sig[k], exp_sig);
      end
    end
    checks++;
    if (nd !== 1 || fd !== DONE_AT) begin
      errors++;
      $display("FAIL drop_done got count %0d cycle %0d exp count 1 cycle %0d", nd, fd, DONE_AT);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    ata_if.ata_rd   = 1'b0;
    ata_if.ata_wr   = 1'b1;
    ata_if.ata_addr = 5'b10000;
    ata_if.ata_in   = 16'hBEEF;
    park = 1'b0;
    repeat (TS + 5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ide_diow !== 1'b0 || ide_data_bus !== 16'hBEEF) begin
      errors++;
      $display("FAIL midrst_pre got diow %b bus %h exp diow 0 bus beef", ide_diow, ide_data_bus);
    end
    reset_n = 1'b0;
    ata_if.ata_wr = 1'b0;
    park = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ide_dior, ide_diow, ide_cs, ide_da, ata_if.ata_done} !== 8'b11_11_000_0) begin
      errors++;
      $display("FAIL midrst_ctrl got %b exp 11110000", {ide_dior, ide_diow, ide_cs, ide_da, ata_if.ata_done});
    end
    checks++;
    if (ide_data_bus !== 16'h0 || ata_if.ata_out !== 16'h0) begin
      errors++;
      $display("FAIL midrst_data got bus %h out %h exp 0000 0000", ide_data_bus, ata_if.ata_out);
    end
    exp_out = 16'h0;
    reset_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ata_if.ata_done !== 1'b0 || ide_cs !== 2'b11) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL midrst_quiet got %0d active cycles exp 0", stray);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_both_requests();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
